mix_columns_seq: RTL

- Column-serial MixColumns / InvMixColumns engine that sequences one shared 32-bit column multiplier over the four columns of a 128-bit AES state.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath.
- Accepts a state with a valid/ready handshake, processes one column per cycle, and holds the result until it is consumed.
- Round-dependent bypass for round 0 and round 10 is built in, so the round controller drives the round number and this block decides whether to mix.

---
 rtl/mix_columns_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns: one shared combinational column
// unit walks the four columns of a latched state, with built-in round bypass.
module mix_columns_seq #(
    parameter bit         BYPASS_EN    = 1'b1,
    parameter logic [3:0] BYPASS_ROUND = 4'd10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid, once raised, is held with its data until ready is seen.
    typedef enum logic [1:0] {S_IDLE, S_COL, S_DONE} state_t;

    state_t         state_q;
    logic [1:0]     col_q;
    logic [127:0]   in_q;
    logic           inv_q;
    logic           byp_q;
    logic [127:0]   out_q;
    logic [31:0]    col_in_d;
    logic [31:0]    col_res_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] r [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv)
                r[i] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            else
                r[i] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    always_comb begin
        col_in_d = in_q[127:96];
        case (col_q)
            2'd0: col_in_d = in_q[127:96];
            2'd1: col_in_d = in_q[95:64];
            2'd2: col_in_d = in_q[63:32];
            2'd3: col_in_d = in_q[31:0];
            default: col_in_d = in_q[127:96];
        endcase
        col_res_d = byp_q ? col_in_d : mix_col(col_in_d, inv_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= 2'd0;
            in_q    <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_q    <= in_state;
                        inv_q   <= in_inv;
                        byp_q   <= BYPASS_EN && ((in_round == 4'd0) || (in_round == BYPASS_ROUND));
                        col_q   <= 2'd0;
                        state_q <= S_COL;
                    end
                end
                S_COL: begin
                    case (col_q)
                        2'd0: out_q[127:96] <= col_res_d;
                        2'd1: out_q[95:64]  <= col_res_d;
                        2'd2: out_q[63:32]  <= col_res_d;
                        2'd3: out_q[31:0]   <= col_res_d;
                        default: out_q[127:96] <= col_res_d;
                    endcase
                    col_q <= col_q + 2'd1;
                    if (col_q == 2'd3)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    // out_q is left untouched here so the result stays stable under backpressure.
                    if (out_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_state = out_q;

endmodule
